seg7_scan_decoder: RTL
======================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 16, minimum cycles a segment/anode pattern must hold unchanged before it is captured (range 2..255).
REQ-002 clk_100MHz  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 a, b, c, d, e, f, g  input  1 each  segment lines, active-low (0 = lit).
REQ-005 dp  input  1  decimal point line, active-low.
REQ-006 an  input  4  digit enables, active-low; an[0] = digit 0 (least significant).
REQ-007 value  output  16  last complete frame, digit n in value[4n+3:4n].
REQ-008 dp_mask  output  4  last complete frame, bit n = digit n dp lit.
REQ-009 blank_mask  output  4  last complete frame, bit n = digit n all segments off.
REQ-010 frame_done  output  1  one-cycle pulse when value/dp_mask/blank_mask update.
REQ-011 value_changed  output  1  one-cycle pulse, coincident with frame_done, when new value differs from previous frame value.
REQ-012 seg_error  output  1  sticky flag: illegal segment pattern or illegal anode pattern captured.

Function
REQ-013 Inputs shall be registered through a two-flop synchronizer on the 12-bit bus {an, dp, g..a} before any use.
REQ-014 A stability counter shall clear whenever the synchronized bus differs from its previous-cycle value and increment (saturating) otherwise.
REQ-015 Capture shall occur exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1; no re-capture until the bus changes.
REQ-016 an = 4'b1111 at capture: ignored, no flag change.
REQ-017 an with more than one bit low at capture: seg_error set, nothing stored.
REQ-018 Decode {g,f,e,d,c,b,a} (active-low hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; 7F = blank (nibble 0, blank bit set).
REQ-019 Any other segment pattern: seg_error set, digit not stored, digit's captured bit unchanged.
REQ-020 Legal capture stores nibble, dp and blank for the selected digit in a shadow set and sets that digit's captured bit.
REQ-021 Recapture of an already-captured digit before frame completion overwrites its shadow entry.
REQ-022 When all four captured bits are set: next cycle copies shadow to value/dp_mask/blank_mask, pulses frame_done, clears all captured bits; frame_done and a new capture in the same cycle: the capture shall land in the cleared bit set for the next frame.
REQ-023 value_changed compares against the value held immediately before the update; the first frame after reset shall compare against 16'h0000.
REQ-024 Outputs value/dp_mask/blank_mask shall change only with frame_done.

Reset
REQ-025 reset_n low shall immediately clear: synchronizer, counter, shadow set, captured bits, value=16'h0000, dp_mask=4'h0, blank_mask=4'h0, frame_done=0, value_changed=0, seg_error=0.
REQ-026 Reset asserted mid-frame discards the partial frame; after release capture restarts with no digits captured.
REQ-027 seg_error shall clear only on reset.

Configuration
REQ-028 Macro SEG7_HEX_DECODE_EN: defined -> A..F patterns of REQ-018 decode as 4'hA..4'hF; undefined -> those patterns are illegal (seg_error set, digit not stored), only 0..9 and blank accepted.

Verification
REQ-029 Scan 1,2,3,4 (an 1110..0111, each held 100 cycles, STABLE_CYCLES=16) -> frame_done once, value=16'h4321, value_changed=1, seg_error=0.
REQ-030 Repeat identical scan -> frame_done pulses, value_changed=0.
REQ-031 Segment glitch of 5 cycles on digit 2 mid-dwell -> no capture of glitch pattern, value=16'h4321 after frame.
REQ-032 Digit 1 pattern 7'h7F with dp=0 -> blank_mask=4'b0010, dp_mask=4'b0010, value[7:4]=0.
REQ-033 an=4'b1100 held 50 cycles -> seg_error=1 and stays 1; pattern 08 with SEG7_HEX_DECODE_EN undefined -> seg_error=1, value unchanged.
REQ-034 reset_n low after 2 digits captured, then full scan of 9,8,7,6 -> single frame_done, value=16'h6789.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a 4-digit hex/decimal value from a multiplexed active-low 7-segment scan; SEG7_HEX_DECODE_EN enables A..F
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  dp_mask,
  output logic [3:0]  blank_mask,
  output logic        frame_done,
  output logic        value_changed,
  output logic        seg_error
);
  localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);
  logic [11:0] sync1, sync2, bus_q;
  logic [7:0]  cnt;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp, sh_blank, captured;
  logic [3:0]  an_c;
  logic [6:0]  seg_c;
  logic        dp_c, cap, an_idle, an_one, dec_ok, dec_blank, store, err, full;
  logic [3:0]  dec_nib;
  logic [1:0]  sel;
  assign {an_c, dp_c, seg_c} = bus_q;
  assign cap     = cnt == CAP_AT;
  assign an_idle = an_c == 4'hF;
  assign an_one  = $onehot(~an_c);
  assign sel     = !an_c[0] ? 2'd0 : !an_c[1] ? 2'd1 : !an_c[2] ? 2'd2 : 2'd3;
  assign store   = cap && an_one && dec_ok;
  assign err     = cap && !an_idle && (!an_one || !dec_ok);
  assign full    = &captured;
  // Synchronize the bus and keep the previous synchronized sample; idle is all lines inactive
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      sync1 <= 12'hFFF;
      sync2 <= 12'hFFF;
      bus_q <= 12'hFFF;
    end else begin
      sync1 <= {an, dp, g, f, e, d, c, b, a};
      sync2 <= sync1;
      bus_q <= sync2;
    end
  // Stability counter: restart on any bus change, saturate so capture fires once per dwell
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) cnt <= 8'd0;
    else cnt <= (sync2 != bus_q) ? 8'd0 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  // Active-low segment pattern to nibble; anything not in the table is illegal
  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_c)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
`endif
      7'h7F: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end
  // Shadow frame: a legal capture (re)writes its digit; a completed frame clears the captured bits
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      sh_val   <= 16'h0000;
      sh_dp    <= 4'h0;
      sh_blank <= 4'h0;
      captured <= 4'h0;
    end else begin
      if (store) begin
        sh_val[{sel, 2'b00} +: 4] <= dec_nib;
        sh_dp[sel]                <= ~dp_c;
        sh_blank[sel]             <= dec_blank;
      end
      captured <= (full ? 4'h0 : captured) | (store ? 4'(4'b0001 << sel) : 4'h0);
    end
  // Publish the shadow frame the cycle after all four digits are in; error flag is sticky
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      value         <= 16'h0000;
      dp_mask       <= 4'h0;
      blank_mask    <= 4'h0;
      frame_done    <= 1'b0;
      value_changed <= 1'b0;
      seg_error     <= 1'b0;
    end else begin
      frame_done    <= full;
      value_changed <= full && (sh_val != value);
      seg_error     <= seg_error | err;
      if (full) begin
        value      <= sh_val;
        dp_mask    <= sh_dp;
        blank_mask <= sh_blank;
      end
    end
endmodule
